// File: rtl/can_fault_confinement_if.sv
// Bundle between the bit-level protocol engine / status register and the CAN
// fault-confinement unit.
//   master: drives the single-cycle event pulses and samples the status.
//   slave : the fault-confinement unit. It samples the events and drives the
//           error-frame request, the error counters and the error state.
interface can_fault_confinement_if #(
  parameter int unsigned CNT_W = 9
);
  // Event pulses from the protocol engine and software.
  logic             err_detect;
  logic             tx_error;
  logic             rx_error;
  logic             rx_error_dom;
  logic             tx_success;
  logic             rx_success;
  logic             recessive_11;
  logic             error_frame_sent;
  logic             restart_req;
  // Status and error-frame request.
  logic             error_frame_req;
  logic             error_frame_passive;
  logic             error_warning;
  logic             error_passive;
  logic             bus_off;
  logic [CNT_W-1:0] tec;
  logic [CNT_W-1:0] rec;
  logic [1:0]       err_state;
  logic             recovery_done;

  modport master (
    output err_detect, tx_error, rx_error, rx_error_dom, tx_success, rx_success,
           recessive_11, error_frame_sent, restart_req,
    input  error_frame_req, error_frame_passive, error_warning, error_passive, bus_off,
           tec, rec, err_state, recovery_done
  );

  modport slave (
    input  err_detect, tx_error, rx_error, rx_error_dom, tx_success, rx_success,
           recessive_11, error_frame_sent, restart_req,
    output error_frame_req, error_frame_passive, error_warning, error_passive, bus_off,
           tec, rec, err_state, recovery_done
  );
endinterface

// File: rtl/can_fault_confinement.sv
// CAN 2.0B fault-confinement unit: TEC/REC error counters, the
// ERROR_ACTIVE / ERROR_PASSIVE / BUS_OFF state machine, bus-off recovery and
// the error-frame request handshake.
// Ports:
//   clk - clock
//   rst - asynchronous, active-high reset
//   bus - slave side of can_fault_confinement_if (event pulses in, status out)
// All status outputs come straight from flops, updated one clk after the pulse.
module can_fault_confinement #(
  parameter int unsigned CNT_W         = 9,
  parameter int unsigned WARN_LIMIT    = 96,
  parameter int unsigned PASSIVE_LIMIT = 128,
  parameter int unsigned BUSOFF_LIMIT  = 256,
  parameter int unsigned REC_RELOAD    = 120,
  parameter int unsigned RECOVERY_CNT  = 128,
  parameter bit          AUTO_RECOVER  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  can_fault_confinement_if.slave bus
);

  localparam int unsigned RcvW = $clog2(RECOVERY_CNT + 1);

  localparam logic [CNT_W-1:0] WarnLim   = CNT_W'(WARN_LIMIT);
  localparam logic [CNT_W-1:0] PassLim   = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0] BusoffLim = CNT_W'(BUSOFF_LIMIT);
  localparam logic [CNT_W-1:0] RecReload = CNT_W'(REC_RELOAD);
  localparam logic [CNT_W:0]   BusoffWide = (CNT_W + 1)'(BUSOFF_LIMIT);
  localparam logic [RcvW-1:0]  RcvTarget = RcvW'(RECOVERY_CNT);

  typedef enum logic [1:0] {
    StActive  = 2'b00,
    StPassive = 2'b01,
    StBusOff  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tec_q, tec_d, rec_q, rec_d;
  logic [RcvW-1:0]  rcv_q, rcv_d;
  logic             armed_q, armed_d;
  logic             latch_q, latch_d;
  logic             req_q;
  logic             flag_q, flag_d;
  logic             done_q, done_d;
  logic             warn_q, warn_d;
  logic [CNT_W:0]   tec_inc, rec_inc;

  always_comb begin
    state_d = state_q;
    tec_d   = tec_q;
    rec_d   = rec_q;
    rcv_d   = rcv_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    // One extra bit so saturation can be detected instead of wrapping.
    tec_inc = {1'b0, tec_q} + (CNT_W + 1)'(8);
    rec_inc = {1'b0, rec_q} + (bus.rx_error_dom ? (CNT_W + 1)'(8) : (CNT_W + 1)'(1));

    if (state_q != StBusOff) begin
      if (bus.tx_error) begin
        tec_d = (tec_inc >= BusoffWide) ? BusoffLim : tec_inc[CNT_W-1:0];
      end else if (bus.tx_success && (tec_q != '0)) begin
        tec_d = tec_q - 1'b1;
      end

      if (bus.rx_error || bus.rx_error_dom) begin
        rec_d = rec_inc[CNT_W] ? '1 : rec_inc[CNT_W-1:0];
      end else if (bus.rx_success) begin
        if (rec_q > CNT_W'(127)) begin
          rec_d = RecReload;
        end else if (rec_q != '0) begin
          rec_d = rec_q - 1'b1;
        end
      end

      // Decide on the counter values that become visible next cycle.
      if (tec_d >= BusoffLim) begin
        state_d = StBusOff;
        armed_d = AUTO_RECOVER;
        rcv_d   = '0;
      end else if ((tec_d >= PassLim) || (rec_d >= PassLim)) begin
        state_d = StPassive;
      end else begin
        state_d = StActive;
      end
    end else begin
      // Counters stay frozen here; only the recovery sequence moves.
      if (bus.restart_req) begin
        armed_d = 1'b1;
      end
      if (armed_q && bus.recessive_11) begin
        if (rcv_q + 1'b1 == RcvTarget) begin
          state_d = StActive;
          tec_d   = '0;
          rec_d   = '0;
          rcv_d   = '0;
          armed_d = AUTO_RECOVER;
          done_d  = 1'b1;
        end else begin
          rcv_d = rcv_q + 1'b1;
        end
      end
    end

    warn_d = ((tec_d >= WarnLim) || (rec_d >= WarnLim)) && (state_d != StBusOff);
  end

  // Error-frame latch: a new detection wins over a same-cycle completion, and
  // bus-off suppresses any request.
  always_comb begin
    latch_d = latch_q;
    if (bus.error_frame_sent) latch_d = 1'b0;
    if (bus.err_detect)       latch_d = 1'b1;
    if ((state_q == StBusOff) || (state_d == StBusOff)) latch_d = 1'b0;

    // Flag type is captured when the latch sets; it drops together with req.
    if (latch_d && !latch_q) begin
      flag_d = (state_q == StPassive);
    end else if (!latch_q) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StActive;
      tec_q   <= '0;
      rec_q   <= '0;
      rcv_q   <= '0;
      armed_q <= AUTO_RECOVER;
      latch_q <= 1'b0;
      req_q   <= 1'b0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tec_q   <= tec_d;
      rec_q   <= rec_d;
      rcv_q   <= rcv_d;
      armed_q <= armed_d;
      latch_q <= latch_d;
      req_q   <= latch_q;
      flag_q  <= flag_d;
      done_q  <= done_d;
      warn_q  <= warn_d;
    end
  end

  assign bus.error_frame_req     = req_q;
  assign bus.error_frame_passive = flag_q;
  assign bus.error_warning       = warn_q;
  assign bus.error_passive       = (state_q == StPassive);
  assign bus.bus_off             = (state_q == StBusOff);
  assign bus.tec                 = tec_q;
  assign bus.rec                 = rec_q;
  assign bus.err_state           = state_q;
  assign bus.recovery_done       = done_q;

endmodule

// File: doc/can_fault_confinement.md
Name: can_fault_confinement

Overview:
- Parametrised CAN 2.0B fault-confinement unit. Maintains the transmit (TEC) and receive (REC) error counters, the error-state machine (ERROR_ACTIVE / ERROR_PASSIVE / BUS_OFF), bus-off recovery and the error-frame request handshake.
- Sits between the bit-level protocol engine, which supplies single-cycle event pulses, and the frame generator and controller status register.

Parameters:
- CNT_W, 9: counter width. Must be ≥ 9.
- WARN_LIMIT, 96: error_warning asserts when TEC or REC is ≥ this value.
- PASSIVE_LIMIT, 128: ERROR_PASSIVE entered when TEC or REC is ≥ this value.
- BUSOFF_LIMIT, 256: BUS_OFF entered when TEC is ≥ this value.
- REC_RELOAD, 120: value REC is reloaded to on rx_success when REC > 127.
- RECOVERY_CNT, 128: number of recessive_11 pulses needed to leave BUS_OFF.
- AUTO_RECOVER, 1: 1 = recovery starts automatically on entering BUS_OFF; 0 = recovery waits for restart_req.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous reset, active-high.
- err_detect, input, 1: pulse; bit, stuff, form, CRC or ack error detected.
- tx_error, input, 1: pulse; transmitter error, TEC += 8.
- rx_error, input, 1: pulse; receiver error, REC += 1.
- rx_error_dom, input, 1: pulse; dominant bit after own error flag, REC += 8.
- tx_success, input, 1: pulse; frame transmitted and acknowledged, TEC -= 1.
- rx_success, input, 1: pulse; frame received correctly, REC decrement or reload.
- recessive_11, input, 1: pulse; 11 consecutive recessive bits observed.
- error_frame_sent, input, 1: pulse; frame generator finished the error frame.
- restart_req, input, 1: pulse; software bus-off restart (used only when AUTO_RECOVER=0).
- error_frame_req, output, 1: level; request an error frame.
- error_frame_passive, output, 1: 1 = send passive flag, 0 = send active flag.
- error_warning, output, 1: warning-limit status.
- error_passive, output, 1: state == ERROR_PASSIVE.
- bus_off, output, 1: state == BUS_OFF.
- tec, output, CNT_W: transmit error counter.
- rec, output, CNT_W: receive error counter.
- err_state, output, 2: 00 = ACTIVE, 01 = PASSIVE, 10 = BUS_OFF.
- recovery_done, output, 1: one-cycle pulse on BUS_OFF → ACTIVE.

Behaviour:
- Reset: all outputs 0, tec = rec = 0, err_state = ACTIVE, recovery counter 0, recovery_armed = AUTO_RECOVER.
- All outputs are registered. Counter and state updates are visible one clk after the input pulse.
- TEC, priority per cycle: tx_error > tx_success.
  - tx_error: TEC = min(TEC + 8, BUSOFF_LIMIT). TEC saturates and never wraps.
  - tx_success: TEC = TEC − 1 if TEC > 0, else unchanged.
- REC, priority per cycle: error > success.
  - rx_error and rx_error_dom in the same cycle: +8 only.
  - REC increments saturate at 2^CNT_W − 1.
  - rx_success with REC > 127: REC = REC_RELOAD.
  - rx_success with 0 < REC ≤ 127: REC −= 1.
  - rx_success with REC = 0: unchanged.
- Counters are frozen while in BUS_OFF, apart from the recovery clear.
- The state machine evaluates the next-cycle counter values:
  - ACTIVE → PASSIVE when TEC ≥ PASSIVE_LIMIT or REC ≥ PASSIVE_LIMIT.
  - ACTIVE or PASSIVE → BUS_OFF when TEC ≥ BUSOFF_LIMIT. BUS_OFF has priority over PASSIVE.
  - PASSIVE → ACTIVE when both counters are < PASSIVE_LIMIT.
  - BUS_OFF → ACTIVE when the recovery counter reaches RECOVERY_CNT while armed. On this transition TEC = REC = 0, the recovery counter is cleared and recovery_done pulses.
- Recovery:
  - With AUTO_RECOVER=1, recovery is armed on BUS_OFF entry.
  - With AUTO_RECOVER=0, recovery is armed by restart_req while in BUS_OFF. restart_req outside BUS_OFF is ignored.
  - recessive_11 pulses are counted only while armed in BUS_OFF.
- error_warning = (TEC ≥ WARN_LIMIT or REC ≥ WARN_LIMIT) and state ≠ BUS_OFF.
- Error-frame handshake:
  - err_detect sets a latch; error_frame_req follows the latch one cycle later.
  - error_frame_passive is sampled from the state when the latch sets and held until the request clears.
  - error_frame_sent clears the latch. If err_detect and error_frame_sent arrive in the same cycle, the latch stays set and a new frame is requested.
  - No requests are made in BUS_OFF. Entering BUS_OFF clears the latch.
- A reset mid-operation, including mid-recovery, returns to the reset state immediately.

Test Plan:
- 16 tx_error pulses from reset → TEC 8, 16, …, 128. PASSIVE on pulse 16; error_warning from pulse 12 (TEC = 96). 16 further pulses → TEC = 256, bus_off = 1, err_state = 10.
- Continue from bus-off with AUTO_RECOVER=1: 127 recessive_11 pulses → still BUS_OFF. 128th pulse → err_state = 00, tec = rec = 0, recovery_done high for exactly 1 cycle.
- AUTO_RECOVER=0, in BUS_OFF: 200 recessive_11 pulses with no restart_req → remains BUS_OFF. Then restart_req followed by 128 pulses → ACTIVE.
- 130 rx_error pulses → REC = 130, PASSIVE. Then one rx_success → REC = 120, ACTIVE. Then rx_error and rx_error_dom in the same cycle → REC = 128.
- tx_error and tx_success in the same cycle with TEC = 8 → TEC = 16. tx_success with TEC = 0 → TEC stays 0.
- err_detect in PASSIVE → error_frame_req = 1, error_frame_passive = 1. err_detect and error_frame_sent together → req stays 1. error_frame_sent alone → req = 0 next cycle. Assert rst mid-request → all outputs 0.
